demux14_reg: RTL and testbench
==============================

// Module: demux14_reg
// PURPOSE
//   Registered 1:4 demultiplexer with valid/ready flow control: the counterpart of mux41.
//   Routes one input word to one of four output channels selected by select.
//   Each channel has a one-entry holding register, so a stalled channel never blocks
//   traffic addressed to the other channels.
//   Sits between a single producer and four independent consumers.
// PARAMETERS
//   W   4  data width of input and each output channel
//   CW  8  width of each per-channel transfer counter (DEMUX_CNT_EN only)
// PORTS
//   clk        in   1    rising-edge clock
//   rst        in   1    asynchronous reset, active-high
//   in         in   W    input data word
//   select     in   2    destination channel: 0->out1, 1->out2, 2->out3, 3->out4
//   in_valid   in   1    producer presents in/select
//   in_ready   out  1    block accepts in/select this cycle
//   out1..out4 out  W    channel data (holding-register contents)
//   out_valid  out  4    bit k: out(k+1) holds a word
//   out_ready  in   4    bit k: consumer k+1 takes the word this cycle
//   xfer_cnt   out  4*CW per-channel accepted-word counts, ch1 in LSBs (DEMUX_CNT_EN only)
// BEHAVIOUR
//   - Reset (async, rst=1): out_valid=4'b0000, out1..out4=0, xfer_cnt=0; in_ready then follows the comb rule.
//   - Per-channel state: EMPTY (out_valid[k]=0) / FULL (out_valid[k]=1).
//   - in_ready = ~out_valid[select] | out_ready[select] (comb, from select and the selected channel).
//   - Accept = in_valid & in_ready. On accept: out[select] <= in, out_valid[select] <= 1 next edge.
//   - Drain: channel k with out_valid[k] & out_ready[k] -> out_valid[k] <= 0, unless same-cycle accept to k.
//   - Simultaneous drain+accept on same channel: FULL->FULL, new word replaces old, no bubble.
//   - Drains on other channels are independent of the accept and may all happen in the same cycle.
//   - Latency: accepted word visible on its out port with out_valid set 1 cycle after accept.
//   - Throughput: 1 word/cycle while destination consumers keep out_ready=1.
//   - Stall: in_valid=1 & in_ready=0 -> nothing changes for that channel.
//     Producer holds in/select stable until accept.
//   - Data in a FULL channel is held stable until drained.
//   - out_ready on an EMPTY channel is ignored.
//   - No reordering within a channel. No ordering guarantee across channels.
//   - rst asserted mid-operation: all held words discarded, all channels EMPTY immediately.
// CONFIGURATION
//   DEMUX_CNT_EN defined:
//     - xfer_cnt present.
//     - Counter k increments by 1 on each accept to channel k.
//     - Wraps modulo 2^CW (8'hFF -> 8'h00).
//     - Reset to 0 by rst.
//   DEMUX_CNT_EN undefined: xfer_cnt port and counters absent; all other behaviour identical.
// TESTING
//   1. Reset: rst=1 mid-traffic -> out_valid=0000, out1..4=0 at once; after release in_ready=1.
//   2. Route all: out_ready=1111, send 4'b0001/0011/0111/1111 with select 0,1,2,3 on consecutive cycles
//      -> each word appears on out1..out4 respectively, 1 cycle after accept, one per cycle.
//   3. Blocked channel: out_ready=1110, send 4'b0001 to sel 0 then 4'b0011 to sel 0
//      -> second in_ready=0, out1 holds 0001; a word to sel 1 is still accepted the same cycle.
//   4. Full pass-through: out1 FULL with 0001, out_ready[0]=1, new 4'b1010 to sel 0
//      -> accepted, out1=1010 next cycle, out_valid[0] stays 1.
//   5. Concurrent drain: channels 1-4 FULL, out_ready=1111, in_valid=0 -> out_valid=0000 next cycle.
//   6. DEMUX_CNT_EN, CW=8: 257 accepts to sel 2 -> xfer_cnt[23:16]=8'h01, other counters 0.

Source files
------------

// File: rtl/demux14_reg.sv
// -----------------------------------------------------------------------------
// demux14_reg
//   Registered 1:4 demultiplexer with valid/ready flow control. One producer
//   word is routed to one of four consumer channels chosen by select. Each
//   channel owns a one-entry holding register. A stalled channel therefore
//   only back-pressures words addressed to it, and never traffic addressed to
//   the other channels.
//
//   Optional feature macro: DEMUX_CNT_EN
//     When it is defined, the block adds per-channel accepted-word counters
//     and the xfer_cnt port.
//
// Parameters
//   W          data width of the input word and of each output channel
//   CW         width of each per-channel transfer counter
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in         input data word
//   select     destination channel (0 -> out1 .. 3 -> out4)
//   in_valid   producer presents in/select
//   in_ready   block accepts in/select this cycle (combinational)
//   out1..out4 channel holding-register contents
//   out_valid  bit k: channel k+1 holds a word
//   out_ready  bit k: consumer k+1 takes the word this cycle
//   xfer_cnt   per-channel accepted-word counts, ch1 in LSBs (DEMUX_CNT_EN)
// -----------------------------------------------------------------------------
module demux14_reg #(
    parameter int unsigned W  = 4,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  in,
    input  logic [1:0]    select,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [W-1:0]  out1,
    output logic [W-1:0]  out2,
    output logic [W-1:0]  out3,
    output logic [W-1:0]  out4,
    output logic [3:0]    out_valid,
    input  logic [3:0]    out_ready
`ifdef DEMUX_CNT_EN
    ,
    output logic [4*CW-1:0] xfer_cnt
`endif
);

    localparam int unsigned NCH = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_e;

    // Parameter sanity check
    if (W == 0 || CW == 0) begin : g_bad_param
        $error("demux14_reg: W and CW must be nonzero");
    end

    chan_state_e    state_q [NCH];
    chan_state_e    state_d [NCH];
    logic [W-1:0]   data_q  [NCH];
    logic [W-1:0]   data_d  [NCH];

    logic           sel_full;
    logic           accept;
    logic [NCH-1:0] wr_en;
    logic [NCH-1:0] drain;

    // Flow control: the selected channel is free if it is empty, or if it
    // drains in this same cycle (this gives full throughput with no bubble).
    always_comb begin
        sel_full = (state_q[select] == FULL);
        in_ready = ~sel_full | out_ready[select];
        accept   = in_valid & in_ready;
        wr_en    = '0;
        drain    = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            wr_en[i] = accept & (select == 2'(i));
            drain[i] = (state_q[i] == FULL) & out_ready[i];
        end
    end

    // Per-channel next state: a write wins over a drain, so a simultaneous
    // drain+accept keeps the channel FULL and replaces the held word.
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            data_d[i]  = data_q[i];
            if (wr_en[i]) begin
                state_d[i] = FULL;
                data_d[i]  = in;
            end else if (drain[i]) begin
                state_d[i] = EMPTY;
            end
        end
    end

    // Channel state and holding registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                state_q[i] <= EMPTY;
                data_q[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                data_q[i]  <= data_d[i];
            end
        end
    end

    // Output mapping
    always_comb begin
        out_valid = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            out_valid[i] = (state_q[i] == FULL);
        end
    end

    assign out1 = data_q[0];
    assign out2 = data_q[1];
    assign out3 = data_q[2];
    assign out4 = data_q[3];

`ifdef DEMUX_CNT_EN
    logic [CW-1:0] cnt_q [NCH];
    logic [CW-1:0] cnt_d [NCH];

    // Accepted-word counters wrap naturally modulo 2^CW
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (wr_en[i]) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        xfer_cnt = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            xfer_cnt[i*CW +: CW] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_demux14_reg.sv
// -----------------------------------------------------------------------------
// tb_demux14_reg
//   Self-checking bench for demux14_reg. The reference model treats each
//   channel as a queue of words: a word is popped when the consumer is ready,
//   and pushed when the producer is accepted. A directed vector table covers
//   routing, blocking, pass-through and concurrent drain. Random traffic,
//   a mid-traffic reset and (with DEMUX_CNT_EN) counter wrap are also covered.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_demux14_reg;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] din;
    logic [1:0]   sel;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out1, out2, out3, out4;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
`ifdef DEMUX_CNT_EN
    logic [4*CW-1:0] xfer_cnt;
`endif

    demux14_reg #(.W(W), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (din),
        .select    (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out4      (out4),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] o [4];
    always_comb begin
        o[0] = out1;
        o[1] = out2;
        o[2] = out3;
        o[3] = out4;
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one queue per channel, plus per-channel accept counts
    logic [W-1:0] chq [4][$];
    int           cnt_m [4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            chq[k].delete();
            cnt_m[k] = 0;
        end
    endtask

    // One clock cycle. It is entered just after a rising edge. It drives the
    // inputs, checks in_ready mid-cycle, advances the model, then checks the
    // registered outputs just after the next edge.
    task automatic cycle(input logic [W-1:0] d, input logic [1:0] s, input logic v,
                         input logic [3:0] r, output logic rdy_seen);
        logic exp_rdy;
        din       = d;
        sel       = s;
        in_valid  = v;
        out_ready = r;
        #2;
        rdy_seen = in_ready;
        exp_rdy  = (chq[s].size() == 0) || r[s];
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        for (int k = 0; k < 4; k++) begin
            if (chq[k].size() != 0 && r[k]) void'(chq[k].pop_front());
        end
        if (v && exp_rdy) begin
            chq[s].push_back(d);
            cnt_m[s]++;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(chq[k].size() != 0));
            if (chq[k].size() != 0) begin
                chk($sformatf("out%0d", k + 1), 64'(o[k]), 64'(chq[k][0]));
            end
        end
`ifdef DEMUX_CNT_EN
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("xfer_cnt[%0d]", k), 64'(xfer_cnt[k*CW +: CW]), 64'(CW'(cnt_m[k])));
        end
`endif
    endtask

    typedef struct {
        logic [W-1:0] din;
        logic [1:0]   sel;
        logic         vld;
        logic [3:0]   ordy;
        logic         exp_rdy;
        logic [3:0]   exp_ov;
        logic [15:0]  exp_outs;   // {out4,out3,out2,out1}
    } vec_t;

    vec_t tbl [15];

    initial begin
        logic rdy;
        logic pending;
        logic [W-1:0] pd;
        logic [1:0] ps;

        // Directed vectors, applied back to back from the reset state
        tbl[0]  = '{4'h1, 2'd0, 1'b1, 4'hF, 1'b1, 4'b0001, 16'h0001};
        tbl[1]  = '{4'h3, 2'd1, 1'b1, 4'hF, 1'b1, 4'b0010, 16'h0031};
        tbl[2]  = '{4'h7, 2'd2, 1'b1, 4'hF, 1'b1, 4'b0100, 16'h0731};
        tbl[3]  = '{4'hF, 2'd3, 1'b1, 4'hF, 1'b1, 4'b1000, 16'hF731};
        tbl[4]  = '{4'h0, 2'd0, 1'b0, 4'hF, 1'b1, 4'b0000, 16'hF731};
        tbl[5]  = '{4'h1, 2'd0, 1'b1, 4'hE, 1'b1, 4'b0001, 16'hF731};
        tbl[6]  = '{4'h3, 2'd0, 1'b1, 4'hE, 1'b0, 4'b0001, 16'hF731};
        tbl[7]  = '{4'h5, 2'd1, 1'b1, 4'hE, 1'b1, 4'b0011, 16'hF751};
        tbl[8]  = '{4'hA, 2'd0, 1'b1, 4'hF, 1'b1, 4'b0001, 16'hF75A};
        tbl[9]  = '{4'h2, 2'd1, 1'b1, 4'h0, 1'b1, 4'b0011, 16'hF72A};
        tbl[10] = '{4'h4, 2'd2, 1'b1, 4'h0, 1'b1, 4'b0111, 16'hF42A};
        tbl[11] = '{4'h8, 2'd3, 1'b1, 4'h0, 1'b1, 4'b1111, 16'h842A};
        tbl[12] = '{4'h6, 2'd3, 1'b1, 4'h0, 1'b0, 4'b1111, 16'h842A};
        tbl[13] = '{4'h0, 2'd0, 1'b0, 4'hF, 1'b1, 4'b0000, 16'h842A};
        tbl[14] = '{4'h9, 2'd2, 1'b1, 4'h4, 1'b1, 4'b0100, 16'h892A};

        // Reset state
        rst = 1'b1; din = '0; sel = '0; in_valid = 1'b0; out_ready = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 64'(out_valid), 64'h0);
        chk("reset outs", 64'({out4, out3, out2, out1}), 64'h0);
        chk("reset in_ready", 64'(in_ready), 64'h1);
`ifdef DEMUX_CNT_EN
        chk("reset xfer_cnt", 64'(xfer_cnt), 64'h0);
`endif
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].din, tbl[i].sel, tbl[i].vld, tbl[i].ordy, rdy);
            chk($sformatf("tbl%0d in_ready", i), 64'(rdy), 64'(tbl[i].exp_rdy));
            chk($sformatf("tbl%0d out_valid", i), 64'(out_valid), 64'(tbl[i].exp_ov));
            chk($sformatf("tbl%0d outs", i), 64'({out4, out3, out2, out1}), 64'(tbl[i].exp_outs));
        end

        // Random traffic; producer holds its word until it is accepted
        pending = 1'b0; pd = '0; ps = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pending) begin
                pending = ($urandom % 4) != 0;
                pd      = W'($urandom);
                ps      = 2'($urandom);
            end
            cycle(pd, ps, pending, 4'($urandom), rdy);
            if (pending && rdy) pending = 1'b0;
        end

        // Reset asserted mid-traffic: fill all channels first
        for (int k = 0; k < 4; k++) cycle(W'(k + 5), 2'(k), 1'b1, 4'h0, rdy);
        chk("prefill out_valid", 64'(out_valid), 64'hF);
        #2 rst = 1'b1;
        #1;
        chk("midrst out_valid", 64'(out_valid), 64'h0);
        chk("midrst outs", 64'({out4, out3, out2, out1}), 64'h0);
`ifdef DEMUX_CNT_EN
        chk("midrst xfer_cnt", 64'(xfer_cnt), 64'h0);
`endif
        model_clear();
        @(posedge clk);
        #1 rst = 1'b0;
        in_valid = 1'b0; sel = 2'd0; out_ready = '0;
        #1;
        chk("post-reset in_ready", 64'(in_ready), 64'h1);
        @(posedge clk);
        #1;

`ifdef DEMUX_CNT_EN
        // Counter wrap: 257 accepts to channel 3 (select 2)
        for (int i = 0; i < 257; i++) cycle(W'(i), 2'd2, 1'b1, 4'hF, rdy);
        chk("cnt ch3 wrap", 64'(xfer_cnt[23:16]), 64'h01);
        chk("cnt others", 64'({xfer_cnt[31:24], xfer_cnt[15:0]}), 64'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
